spi_frame_sequencer: RTL and testbench
======================================

SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- SPI_DATA_WIDTH, 8, word width shared with the SPI master.
- FIFO_DEPTH, 16, entries per TX/RX FIFO, power of two >= 2.
- LEN_WIDTH, 8, frame length field width.
- GAP_CYCLES, 8, post-frame idle cycles, >= master CS hold + CS disable counts + 3.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clkIn  in  1  single clock.
- rstIn  in  1  reset, asynchronous, active-high.
- startIn  in  1  frame start request.
- lenIn  in  LEN_WIDTH  words in frame.
- busyOut  out  1  frame or gap in progress.
- doneOut  out  1  one-cycle pulse when the last RX word is captured.
- txWrEnIn  in  1  TX FIFO push.
- txDataIn  in  SPI_DATA_WIDTH  TX push data.
- txFullOut  out  1  TX FIFO full.
- rxRdEnIn  in  1  RX FIFO pop.
- rxDataOut  out  SPI_DATA_WIDTH  RX FIFO head, first-word fall-through.
- rxEmptyOut  out  1  RX FIFO empty.
- txUnderrunOut  out  1  sticky flag.
- rxOverflowOut  out  1  sticky flag.
- clrFlagsIn  in  1  clears sticky flags.
- spiEnOut  out  1  to master enIn.
- spiDataOut  out  SPI_DATA_WIDTH  to master dataRxIn (MOSI word).
- spiValidIn  in  1  from master validDataOut.
- spiDataIn  in  SPI_DATA_WIDTH  from master dataTxOut (MISO word).

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and GAP; busyOut SHALL be 1 in RUN and GAP.
REQ-004 In IDLE, startIn=1 with lenIn!=0 SHALL load remaining=lenIn, pop the TX head into spiDataOut, assert spiEnOut and enter RUN on the next edge.
REQ-005 startIn SHALL be ignored when lenIn=0 or when not in IDLE.
REQ-006 spiEnOut SHALL be registered; with lenIn=1 it SHALL be high for exactly one cycle after start.
REQ-007 With lenIn>1, spiEnOut SHALL stay high until the spiValidIn pulse that leaves remaining=1, and go low the following cycle.
REQ-008 On each spiValidIn in RUN, remaining SHALL decrement; if remaining was >1, the next TX word SHALL be popped into spiDataOut, visible the following cycle.
REQ-009 A pop from an empty TX FIFO SHALL drive spiDataOut=0 and set txUnderrunOut.
REQ-010 The RX capture strobe SHALL be spiValidIn delayed one cycle; on the strobe, spiDataIn SHALL be pushed into the RX FIFO.
REQ-011 A capture into a full RX FIFO SHALL drop the word and set rxOverflowOut.
REQ-012 The capture strobe of the last word SHALL pulse doneOut and move the FSM to GAP.
REQ-013 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.
REQ-014 spiValidIn outside RUN SHALL be ignored.
REQ-015 A TX push SHALL be accepted when the FIFO is not full, or when it is full with a same-cycle pop; otherwise the push SHALL be dropped silently.
REQ-016 A simultaneous RX push and rxRdEnIn on a full RX FIFO SHALL accept both; rxRdEnIn when empty SHALL be ignored.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-018 clrFlagsIn SHALL clear both sticky flags; a same-cycle set SHALL win.

Reset
REQ-019 rstIn=1 SHALL asynchronously force state=IDLE, remaining=0, both FIFOs empty, spiEnOut=0, spiDataOut=0, doneOut=0, busyOut=0, sticky flags=0, txFullOut=0, rxEmptyOut=1, rxDataOut=0.
REQ-020 A reset during RUN SHALL abandon the frame; the master is reset on the same rstIn.

Verification
REQ-021 Push A5,3C; start lenIn=2; loopback MISO=MOSI -> spiEnOut high until the first spiValidIn, RX holds A5,3C, doneOut pulses once, busyOut low GAP_CYCLES cycles after doneOut.
REQ-022 Push 81; start lenIn=1 -> spiEnOut high for exactly 1 cycle, one word 81 received, master exits after 8 SCLK.
REQ-023 Start lenIn=3 with only 1 TX word -> words 2 and 3 sent as 00, txUnderrunOut=1 until clrFlagsIn.
REQ-024 Fill RX with 16 words, run lenIn=1 without popping -> rxOverflowOut=1, RX contents unchanged.
REQ-025 Start during GAP and start with lenIn=0 -> both ignored, no spiEnOut.
REQ-026 Assert rstIn mid-word 2 of 4 -> all outputs at reset values immediately; new frame lenIn=1 then completes normally.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// SPI frame sequencer: feeds a SPI master from a TX FIFO, collects its received
// words into an RX FIFO and frames each transfer with a fixed post-frame idle gap.
module spi_frame_sequencer #(
  parameter int unsigned SPI_DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic                      startIn,
  input  logic [LEN_WIDTH-1:0]      lenIn,
  output logic                      busyOut,
  output logic                      doneOut,
  input  logic                      txWrEnIn,
  input  logic [SPI_DATA_WIDTH-1:0] txDataIn,
  output logic                      txFullOut,
  input  logic                      rxRdEnIn,
  output logic [SPI_DATA_WIDTH-1:0] rxDataOut,
  output logic                      rxEmptyOut,
  output logic                      txUnderrunOut,
  output logic                      rxOverflowOut,
  input  logic                      clrFlagsIn,
  output logic                      spiEnOut,
  output logic [SPI_DATA_WIDTH-1:0] spiDataOut,
  input  logic                      spiValidIn,
  input  logic [SPI_DATA_WIDTH-1:0] spiDataIn
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StGap} stateE;
  stateE stateQ, stateD;

  logic [LEN_WIDTH-1:0]      remainingQ;
  logic [GW-1:0]             gapCntQ;
  logic                      capStrobeQ, capLastQ;

  logic [SPI_DATA_WIDTH-1:0] txMem [FIFO_DEPTH];
  logic [AW-1:0]             txWrPtrQ, txRdPtrQ;
  logic [CW-1:0]             txCntQ;
  logic [SPI_DATA_WIDTH-1:0] rxMem [FIFO_DEPTH];
  logic [AW-1:0]             rxWrPtrQ, rxRdPtrQ;
  logic [CW-1:0]             rxCntQ;

  logic startAcc, wordDone, txPop, txPopOk, txPush, txEmpty, txFull;
  logic rxPush, rxPopOk, rxFull, rxEmpty, lastCapture, gapEnd, enStop;

  assign startAcc    = (stateQ == StIdle) && startIn && (lenIn != '0);
  // Valids only count while words are still owed in the current frame.
  assign wordDone    = (stateQ == StRun) && spiValidIn && (remainingQ != '0);
  assign txPop       = startAcc || (wordDone && (remainingQ > LEN_WIDTH'(1)));
  assign lastCapture = capStrobeQ && capLastQ;
  assign gapEnd      = (stateQ == StGap) && (gapCntQ == '0);
  // Drop enable once the master is committed to the final word.
  assign enStop      = (remainingQ <= LEN_WIDTH'(1)) ||
                       (wordDone && (remainingQ == LEN_WIDTH'(2)));

  assign txEmpty     = (txCntQ == '0);
  assign txFull      = (txCntQ == CW'(FIFO_DEPTH));
  assign txPopOk     = txPop && !txEmpty;
  assign txPush      = txWrEnIn && (!txFull || txPopOk);
  assign rxEmpty     = (rxCntQ == '0);
  assign rxFull      = (rxCntQ == CW'(FIFO_DEPTH));
  assign rxPopOk     = rxRdEnIn && !rxEmpty;
  assign rxPush      = capStrobeQ && (!rxFull || rxPopOk);

  assign txFullOut   = txFull;
  assign rxEmptyOut  = rxEmpty;
  assign rxDataOut   = rxEmpty ? '0 : rxMem[rxRdPtrQ];

  // FSM state register.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  // FSM next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (startAcc)    stateD = StRun;
      StRun:   if (lastCapture) stateD = StGap;
      StGap:   if (gapEnd)      stateD = StIdle;
      default:                  stateD = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busyOut = (stateQ != StIdle);
    doneOut = lastCapture;
  end

  // Frame counters, SPI handshake and capture pipeline.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      remainingQ <= '0;
      gapCntQ    <= '0;
      capStrobeQ <= 1'b0;
      capLastQ   <= 1'b0;
      spiEnOut   <= 1'b0;
      spiDataOut <= '0;
    end else begin
      if (startAcc)      remainingQ <= lenIn;
      else if (wordDone) remainingQ <= remainingQ - LEN_WIDTH'(1);
      if (lastCapture)                     gapCntQ <= GW'(GAP_CYCLES - 1);
      else if (stateQ == StGap && !gapEnd) gapCntQ <= gapCntQ - GW'(1);
      capStrobeQ <= wordDone;
      capLastQ   <= wordDone && (remainingQ == LEN_WIDTH'(1));
      if (startAcc)                         spiEnOut <= 1'b1;
      else if (stateQ != StRun || enStop)   spiEnOut <= 1'b0;
      if (txPop) spiDataOut <= txEmpty ? '0 : txMem[txRdPtrQ];
    end
  end

  // Sticky error flags; a same-cycle set beats the clear.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      txUnderrunOut <= 1'b0;
      rxOverflowOut <= 1'b0;
    end else begin
      txUnderrunOut <= (txPop && txEmpty) || (txUnderrunOut && !clrFlagsIn);
      rxOverflowOut <= (capStrobeQ && !rxPush) || (rxOverflowOut && !clrFlagsIn);
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      txWrPtrQ <= '0;
      txRdPtrQ <= '0;
      txCntQ   <= '0;
    end else begin
      if (txPush)  txWrPtrQ <= txWrPtrQ + AW'(1);
      if (txPopOk) txRdPtrQ <= txRdPtrQ + AW'(1);
      txCntQ <= txCntQ + CW'(txPush) - CW'(txPopOk);
    end
  end

  // TX FIFO storage.
  always_ff @(posedge clkIn) begin
    if (txPush) txMem[txWrPtrQ] <= txDataIn;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      rxWrPtrQ <= '0;
      rxRdPtrQ <= '0;
      rxCntQ   <= '0;
    end else begin
      if (rxPush)  rxWrPtrQ <= rxWrPtrQ + AW'(1);
      if (rxPopOk) rxRdPtrQ <= rxRdPtrQ + AW'(1);
      rxCntQ <= rxCntQ + CW'(rxPush) - CW'(rxPopOk);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clkIn) begin
    if (rxPush) rxMem[rxWrPtrQ] <= spiDataIn;
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Randomized scoreboard bench for spi_frame_sequencer with a behavioural SPI master.
module tb_spi_frame_sequencer;

  localparam int DW = 8, DEPTH = 16, LW = 8, GAP = 8;

  logic          clkIn = 1'b0, rstIn = 1'b1;
  logic          startIn = 1'b0, txWrEnIn = 1'b0, rxRdEnIn = 1'b0, clrFlagsIn = 1'b0;
  logic [LW-1:0] lenIn = '0;
  logic [DW-1:0] txDataIn = '0, spiDataIn = '0;
  logic          mValid = 1'b0, strayValid = 1'b0, spiValidIn;
  logic          busyOut, doneOut, txFullOut, rxEmptyOut, txUnderrunOut, rxOverflowOut;
  logic          spiEnOut;
  logic [DW-1:0] rxDataOut, spiDataOut;

  assign spiValidIn = mValid | strayValid;

  spi_frame_sequencer #(
    .SPI_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW), .GAP_CYCLES(GAP)
  ) dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .lenIn(lenIn), .busyOut(busyOut),
    .doneOut(doneOut), .txWrEnIn(txWrEnIn), .txDataIn(txDataIn), .txFullOut(txFullOut),
    .rxRdEnIn(rxRdEnIn), .rxDataOut(rxDataOut), .rxEmptyOut(rxEmptyOut),
    .txUnderrunOut(txUnderrunOut), .rxOverflowOut(rxOverflowOut), .clrFlagsIn(clrFlagsIn),
    .spiEnOut(spiEnOut), .spiDataOut(spiDataOut), .spiValidIn(spiValidIn),
    .spiDataIn(spiDataIn)
  );

  always #5 clkIn = ~clkIn;

  int passCnt = 0, checkCnt = 0, wordsSeen = 0;
  logic [DW-1:0] txModelQ[$], expRxQ[$], expMosiQ[$], misoQ[$];
  int lenQ[$];
  bit expUnder = 0, expOver = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clkIn);
    #2;
  endtask

  // Behavioural SPI master: one word per 3..6 cycles, continues while enable is high.
  initial begin
    forever begin
      @(negedge clkIn);
      if (!rstIn && spiEnOut) begin
        int len, k, wl;
        bit ab, cont;
        logic [DW-1:0] mo, mi;
        ab = 0; cont = 1; k = 0;
        check("frame_expected", int'(lenQ.size() > 0), 1);
        len = (lenQ.size() > 0) ? lenQ.pop_front() : 1;
        while (cont && !ab) begin
          k++;
          wordsSeen++;
          mo = spiDataOut;
          check("mosi_expected", int'(expMosiQ.size() > 0), 1);
          if (expMosiQ.size() > 0) check("mosi_word", mo, expMosiQ.pop_front());
          mi = (misoQ.size() > 0) ? misoQ.pop_front() : '0;
          wl = $urandom_range(3, 6);
          for (int c = 0; c < wl - 1 && !ab; c++) begin
            @(negedge clkIn);
            ab = rstIn;
          end
          if (!ab) begin
            mValid = 1'b1;
            spiDataIn = mi;
            cont = spiEnOut;
            check("en_at_word_end", cont, k < len);
            @(negedge clkIn);
            mValid = 1'b0;
            ab = rstIn;
            if (!ab) check("en_after_word", spiEnOut, (len - k) >= 2);
            if (k >= len) cont = 0;
          end
        end
        mValid = 1'b0;
      end
    end
  end

  // RX monitor: every accepted pop is compared against the scoreboard.
  always @(negedge clkIn) begin
    if (!rstIn && rxRdEnIn && !rxEmptyOut) begin
      check("rx_expected", int'(expRxQ.size() > 0), 1);
      if (expRxQ.size() > 0) check("rx_word", rxDataOut, expRxQ.pop_front());
    end
  end

  task automatic pushTx(logic [DW-1:0] d);
    txWrEnIn = 1'b1;
    txDataIn = d;
    if (txModelQ.size() < DEPTH) txModelQ.push_back(d);
    step();
    txWrEnIn = 1'b0;
  endtask

  // Reference model: words leave TX in order (0 when empty), land in RX while room remains.
  task automatic issueFrame(int len, bit loopback);
    logic [DW-1:0] m, mi;
    for (int i = 0; i < len; i++) begin
      if (txModelQ.size() > 0) m = txModelQ.pop_front();
      else begin m = '0; expUnder = 1; end
      expMosiQ.push_back(m);
      mi = loopback ? m : DW'($urandom);
      misoQ.push_back(mi);
      if (expRxQ.size() < DEPTH) expRxQ.push_back(mi);
      else expOver = 1;
    end
    lenQ.push_back(len);
  endtask

  task automatic runFrame(int len, bit loopback, bit gapStart);
    int enCnt, hi, extra;
    bit got, lastBusy;
    issueFrame(len, loopback);
    startIn = 1'b1;
    lenIn = LW'(len);
    step();
    startIn = 1'b0;
    enCnt = 0; got = 0; hi = 0; extra = 0; lastBusy = 1;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clkIn);
      if (spiEnOut) enCnt++;
      if (doneOut) got = 1;
    end
    check("done_seen", got, 1);
    if (len == 1) check("en_one_cycle", enCnt, 1);
    for (int c = 0; c <= GAP; c++) begin
      if (gapStart && c == 2) begin startIn = 1'b1; lenIn = LW'(2); end
      if (c == 3) startIn = 1'b0;
      @(negedge clkIn);
      if (c < GAP) hi += int'(busyOut);
      else lastBusy = busyOut;
      extra += int'(doneOut || spiEnOut);
    end
    startIn = 1'b0;
    repeat (3) begin
      @(negedge clkIn);
      extra += int'(busyOut || spiEnOut || doneOut);
    end
    step();
    check("gap_len", hi, GAP);
    check("idle_after_gap", lastBusy, 0);
    check("quiet_after_done", extra, 0);
    check("mosi_consumed", expMosiQ.size(), 0);
    check("underrun_flag", txUnderrunOut, expUnder);
    check("overflow_flag", rxOverflowOut, expOver);
  endtask

  task automatic drainRx();
    int n, g;
    n = expRxQ.size();
    g = 0;
    while (!rxEmptyOut && g < DEPTH + 4) begin
      rxRdEnIn = 1'b1;
      step();
      g++;
    end
    rxRdEnIn = 1'b0;
    check("rx_count", g, n);
    check("rx_empty", rxEmptyOut, 1);
  endtask

  task automatic clearFlags();
    clrFlagsIn = 1'b1;
    step();
    clrFlagsIn = 1'b0;
    expUnder = 0;
    expOver = 0;
    check("underrun_cleared", txUnderrunOut, 0);
    check("overflow_cleared", rxOverflowOut, 0);
  endtask

  task automatic resetChecks();
    check("rst_busy", busyOut, 0);
    check("rst_done", doneOut, 0);
    check("rst_spi_en", spiEnOut, 0);
    check("rst_spi_data", spiDataOut, 0);
    check("rst_tx_full", txFullOut, 0);
    check("rst_rx_empty", rxEmptyOut, 1);
    check("rst_rx_data", rxDataOut, 0);
    check("rst_underrun", txUnderrunOut, 0);
    check("rst_overflow", rxOverflowOut, 0);
  endtask

  initial begin
    int ws0, n;
    repeat (2) step();
    resetChecks();
    rstIn = 1'b0;
    step();

    // Stray valid while idle must not capture anything.
    strayValid = 1'b1;
    step();
    strayValid = 1'b0;
    repeat (3) step();
    check("stray_valid_rx_empty", rxEmptyOut, 1);
    check("stray_valid_idle", busyOut, 0);

    // Two-word loopback frame, then single-word frame.
    pushTx(8'hA5);
    pushTx(8'h3C);
    runFrame(2, 1, 0);
    drainRx();
    pushTx(8'h81);
    runFrame(1, 1, 0);
    drainRx();

    // Start during the gap and a zero-length start are both ignored.
    pushTx(8'h47);
    runFrame(1, 0, 1);
    drainRx();
    startIn = 1'b1;
    lenIn = '0;
    step();
    startIn = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clkIn);
      n += int'(busyOut || spiEnOut);
    end
    step();
    check("len0_ignored", n, 0);

    // TX underrun: three words requested, one available.
    pushTx(8'h5E);
    runFrame(3, 0, 0);
    clearFlags();
    drainRx();

    // TX full drop, RX fill to capacity, then RX overflow.
    for (int i = 0; i < DEPTH + 1; i++) pushTx(DW'($urandom));
    check("tx_full", txFullOut, 1);
    runFrame(DEPTH, 0, 0);
    check("tx_drained", txFullOut, 0);
    pushTx(8'hC3);
    runFrame(1, 0, 0);
    drainRx();
    clearFlags();

    // Reset in the middle of word 2 of a four-word frame.
    for (int i = 0; i < 4; i++) pushTx(DW'($urandom));
    issueFrame(4, 0);
    ws0 = wordsSeen;
    startIn = 1'b1;
    lenIn = LW'(4);
    step();
    startIn = 1'b0;
    for (int c = 0; c < 300 && wordsSeen < ws0 + 2; c++) @(negedge clkIn);
    check("reached_word2", int'(wordsSeen >= ws0 + 2), 1);
    step();
    rstIn = 1'b1;
    #1;
    resetChecks();
    step();
    step();
    txModelQ.delete(); expRxQ.delete(); expMosiQ.delete(); misoQ.delete(); lenQ.delete();
    expUnder = 0;
    expOver = 0;
    rstIn = 1'b0;
    step();
    pushTx(8'h5A);
    runFrame(1, 0, 0);
    drainRx();

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) pushTx(DW'($urandom));
      runFrame($urandom_range(1, 5), 1'($urandom_range(0, 1)), 0);
      drainRx();
      if (expUnder || expOver) clearFlags();
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
